datapath_sequencer: RTL
=======================

Name: datapath_sequencer

Overview:
- Multi-cycle control FSM that sequences the single-cycle datapath.
- Accepts one 32-bit MIPS instruction per valid/ready handshake and latches it onto the datapath instruction bus.
- Drives the datapath controls (RegDst, ALUSrc, ALUCtrl, MemtoReg, MemRead, MemWrite, RegWrite) in ordered phases, so edge-sensitive register/memory writes happen only after operands settle.
- Signals completion per instruction and keeps a retired-instruction count.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.
- EN_ADDI, 1, when 1 opcode 0x08 (addi) is legal; when 0 it is treated as illegal.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- resetN  input  1  synchronous active-low reset.
- instrValid  input  1  upstream has an instruction on instrIn.
- instrIn  input  32  instruction word.
- instrReady  output  1  sequencer can accept an instruction.
- instruction  output  32  latched instruction, wired to the datapath.
- RegDst  output  1  1 = write register rt [20:16], 0 = rd [15:11].
- ALUSrc  output  1  1 = ALU op2 from sign-extended immediate, 0 = readData2.
- ALUCtrl  output  4  and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100.
- MemtoReg  output  1  1 = writeback from memory, 0 = from ALU.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write strobe (single-cycle pulse).
- RegWrite  output  1  register write strobe (single-cycle pulse; regfile writes on its rising edge).
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  qualifies done; 1 = instruction was undecodable.
- retired  output  CNT_WIDTH  count of legally retired instructions.

Behaviour:
- Reset (resetN=0 at an edge):
  - state goes to IDLE.
  - instruction, all controls, done, illegal and retired go to 0.
  - Reset overrides everything. Mid-operation it aborts the instruction: no pending strobe fires, and retired is not incremented.
- States: IDLE, DECODE, EXEC, MEM, WB, DONE.
- instrReady = 1 only in IDLE and not in reset.
- Accept: instrValid && instrReady at an edge latches instrIn into instruction and moves to DECODE. instrIn is ignored outside IDLE.
- DECODE: registers RegDst/ALUSrc/ALUCtrl/MemtoReg from the latched word.
  - op 0x00, funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt: RegDst=0, ALUSrc=0, MemtoReg=0.
  - op 0x23 lw: RegDst=1, ALUSrc=1, add, MemtoReg=1.
  - op 0x2B sw: ALUSrc=1, add, RegDst=0, MemtoReg=0.
  - op 0x08 addi (EN_ADDI=1): RegDst=1, ALUSrc=1, add, MemtoReg=0.
  - Anything else: illegal. All controls go to 0 and the next state is DONE.
  - Legal instructions go next to EXEC.
- EXEC: controls held; ALU settles. Next state is MEM for lw/sw, otherwise WB.
- MEM:
  - lw: MemRead=1, next WB.
  - sw: MemWrite=1 for exactly this cycle, next DONE.
- WB:
  - RegWrite=1 for exactly this cycle, unless the destination register (rd or rt per RegDst) is 0. In that case RegWrite stays 0 so $zero is preserved.
  - MemRead stays 1 through WB for lw.
  - Next state is DONE.
- DONE:
  - done=1 and illegal as decoded.
  - MemRead, MemWrite and RegWrite are 0.
  - retired += 1 if legal; it wraps modulo 2^CNT_WIDTH.
  - Next state is IDLE.
- Static controls and instruction hold their values until the next DECODE/accept.
- Latency, counted from the accept edge (cycle 0) to the done cycle:
  - R-type/addi: 4.
  - lw: 5.
  - sw: 4.
  - illegal: 2.
- Throughput: the next accept can occur no earlier than the edge after DONE.
- Only one of MemWrite or RegWrite is ever high in a given cycle. Each strobe is low in the cycle before and the cycle after it is asserted.
- Outputs are registered; no combinational path from instrIn/instrValid to any output except instrReady (state-only).

Test Plan:
- Reset, then add $3,$1,$2 (0x00221820) with valid held: instrReady=0 cycles 1-4; RegWrite high only cycle 3 with RegDst=0, ALUCtrl=0010; done cycle 4; retired=1; instrReady=1 cycle 5.
- lw $5,8($1) (0x8C250008): ALUSrc=1, RegDst=1, MemtoReg=1; MemRead=1 cycles 3-4; RegWrite only cycle 4; done cycle 5.
- sw $5,-4($1) (0xAC25FFFC): MemWrite high only cycle 3; RegWrite never asserts; done cycle 4.
- add $0,$1,$2 (0x00220020): RegWrite stays 0 throughout; done cycle 4; retired increments.
- Opcode 0x3F (0xFC000000): done and illegal both 1 in cycle 2; no strobes; retired unchanged. With EN_ADDI=0, addi 0x20210005 also gives done+illegal.
- Reset pulsed during EXEC of lw: no MemRead/RegWrite afterward, retired unchanged. Then retired preloaded to 0xFFFFFFFF plus one legal instruction: retired wraps to 0.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for a single-cycle MIPS datapath: accepts one
// instruction per handshake and walks it through DECODE/EXEC/MEM/WB/DONE phases.
module datapath_sequencer #(
  parameter int CNT_WIDTH = 32,
  parameter int EN_ADDI   = 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 instrValid,
  input  logic [31:0]          instrIn,
  output logic                 instrReady,
  output logic [31:0]          instruction,
  output logic                 RegDst,
  output logic                 ALUSrc,
  output logic [3:0]           ALUCtrl,
  output logic                 MemtoReg,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 done,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Handshake: an instruction transfers on a rising edge where instrValid and
  // instrReady are both 1; instrReady depends only on state and reset.

  logic [2:0]           state_q, state_d;
  logic [31:0]          instruction_q, instruction_d;
  logic                 reg_dst_q, reg_dst_d;
  logic                 alu_src_q, alu_src_d;
  logic [3:0]           alu_ctrl_q, alu_ctrl_d;
  logic                 mem_to_reg_q, mem_to_reg_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic                 reg_write_q, reg_write_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 is_lw_q, is_lw_d;
  logic                 is_sw_q, is_sw_d;
  logic                 legal_q, legal_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic       dec_legal;
  logic       dec_lw;
  logic       dec_sw;
  logic       dec_reg_dst;
  logic       dec_alu_src;
  logic       dec_mem_to_reg;
  logic [3:0] dec_alu_ctrl;
  logic [4:0] dest_reg;

  always_comb begin
    op             = instruction_q[31:26];
    funct          = instruction_q[5:0];
    dec_legal      = 1'b1;
    dec_lw         = 1'b0;
    dec_sw         = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_ctrl   = 4'b0010;
    case (op)
      6'h00: begin
        case (funct)
          6'h20:   dec_alu_ctrl = 4'b0010;
          6'h22:   dec_alu_ctrl = 4'b0110;
          6'h24:   dec_alu_ctrl = 4'b0000;
          6'h25:   dec_alu_ctrl = 4'b0001;
          6'h27:   dec_alu_ctrl = 4'b1100;
          6'h2A:   dec_alu_ctrl = 4'b0111;
          default: dec_legal    = 1'b0;
        endcase
      end
      6'h23: begin
        dec_lw         = 1'b1;
        dec_reg_dst    = 1'b1;
        dec_alu_src    = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      6'h2B: begin
        dec_sw      = 1'b1;
        dec_alu_src = 1'b1;
      end
      6'h08: begin
        if (EN_ADDI != 0) begin
          dec_reg_dst = 1'b1;
          dec_alu_src = 1'b1;
        end else begin
          dec_legal = 1'b0;
        end
      end
      default: dec_legal = 1'b0;
    endcase
    // Undecodable words drive every control to 0 so the datapath stays inert.
    if (!dec_legal) begin
      dec_lw         = 1'b0;
      dec_sw         = 1'b0;
      dec_reg_dst    = 1'b0;
      dec_alu_src    = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_alu_ctrl   = 4'b0000;
    end
  end

  assign dest_reg = reg_dst_q ? instruction_q[20:16] : instruction_q[15:11];

  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    reg_dst_d     = reg_dst_q;
    alu_src_d     = alu_src_q;
    alu_ctrl_d    = alu_ctrl_q;
    mem_to_reg_d  = mem_to_reg_q;
    is_lw_d       = is_lw_q;
    is_sw_d       = is_sw_q;
    legal_d       = legal_q;
    case (state_q)
      S_IDLE: begin
        if (instrValid) begin
          instruction_d = instrIn;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        reg_dst_d    = dec_reg_dst;
        alu_src_d    = dec_alu_src;
        alu_ctrl_d   = dec_alu_ctrl;
        mem_to_reg_d = dec_mem_to_reg;
        is_lw_d      = dec_lw;
        is_sw_d      = dec_sw;
        legal_d      = dec_legal;
        state_d      = dec_legal ? S_EXEC : S_DONE;
      end
      S_EXEC:  state_d = (is_lw_q || is_sw_q) ? S_MEM : S_WB;
      S_MEM:   state_d = is_lw_q ? S_WB : S_DONE;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    mem_read_d  = is_lw_q && ((state_d == S_MEM) || (state_d == S_WB));
    mem_write_d = is_sw_q && (state_d == S_MEM);
    reg_write_d = (state_d == S_WB) && (dest_reg != 5'd0);
    done_d      = (state_d == S_DONE);
    illegal_d   = (state_d == S_DONE) && !legal_d;
    retired_d   = retired_q;
    if ((state_d == S_DONE) && legal_d) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      instruction_q <= '0;
      reg_dst_q     <= 1'b0;
      alu_src_q     <= 1'b0;
      alu_ctrl_q    <= 4'b0000;
      mem_to_reg_q  <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      retired_q     <= '0;
      is_lw_q       <= 1'b0;
      is_sw_q       <= 1'b0;
      legal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      reg_dst_q     <= reg_dst_d;
      alu_src_q     <= alu_src_d;
      alu_ctrl_q    <= alu_ctrl_d;
      mem_to_reg_q  <= mem_to_reg_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      reg_write_q   <= reg_write_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      retired_q     <= retired_d;
      is_lw_q       <= is_lw_d;
      is_sw_q       <= is_sw_d;
      legal_q       <= legal_d;
    end
  end

  assign instrReady  = (state_q == S_IDLE) && resetN;
  assign instruction = instruction_q;
  assign RegDst      = reg_dst_q;
  assign ALUSrc      = alu_src_q;
  assign ALUCtrl     = alu_ctrl_q;
  assign MemtoReg    = mem_to_reg_q;
  assign MemRead     = mem_read_q;
  assign MemWrite    = mem_write_q;
  assign RegWrite    = reg_write_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule
